spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on each of sck, ss_n and mosi (minimum 2).
REQ-003 clk  in  1  system clock; all logic in this single clock domain, rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 sck  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 ss_n  in  1  slave select from master, active-low, asynchronous.
REQ-007 mosi  in  1  serial data from master, asynchronous.
REQ-008 miso  out  1  serial data to master; registered.
REQ-009 data_in  in  WIDTH  word to transmit in a later frame.
REQ-010 load  in  1  one-cycle strobe writing data_in into the TX holding register.
REQ-011 tx_full  out  1  TX holding register occupied.
REQ-012 data_out  out  WIDTH  last complete received word; holds until the next word completes.
REQ-013 new_data  out  1  one-cycle pulse when data_out updates.
REQ-014 busy  out  1  high while slave is selected (ACTIVE state).
REQ-015 tx_underrun  out  1  one-cycle pulse when a word starts with the holding register empty.

Function
REQ-016 sck, ss_n and mosi SHALL pass through SYNC_STAGES flops; edges are detected from the last two synchronized samples.
REQ-017 Supported timing: sck high and low times of at least 4 clk cycles each; ss_n setup to the first sck rise of at least 4 clk cycles.
REQ-018 States: IDLE and ACTIVE. IDLE->ACTIVE on synchronized ss_n falling edge. ACTIVE->IDLE on synchronized ss_n high, independent of bit count.
REQ-019 On IDLE->ACTIVE: bit_ctr=0; tx_word loaded from the holding register (tx_full cleared), or 0 with a tx_underrun pulse if empty; miso=tx_word[WIDTH-1] on the next cycle.
REQ-020 On each synchronized sck rising edge in ACTIVE: rx_shift = {rx_shift[WIDTH-2:0], mosi_sync}; bit_ctr increments.
REQ-021 On the rising edge where bit_ctr = WIDTH-1: data_out = {rx_shift[WIDTH-2:0], mosi_sync}; new_data pulses on the next cycle; bit_ctr wraps to 0; tx_word reloads per REQ-019, including underrun.
REQ-022 On each synchronized sck falling edge in ACTIVE: miso = tx_word[WIDTH-1-bit_ctr].
REQ-023 In IDLE, miso SHALL be 0 and sck edges SHALL be ignored.
REQ-024 Deselect mid-word: partial rx bits discarded; no new_data; data_out unchanged; bit_ctr=0; a consumed tx_word is not returned to the holding register.
REQ-025 load with tx_full=0: holding register = data_in, tx_full=1 next cycle.
REQ-026 load with tx_full=1 and no consumption in the same cycle: ignored; holding register unchanged.
REQ-027 load in the same cycle as consumption: old value goes to tx_word; data_in is captured; tx_full stays 1.
REQ-028 Back-to-back words within one selection SHALL be supported without gaps; bit_ctr wraps modulo WIDTH.

Reset
REQ-029 rst SHALL override all other inputs in the cycle it is sampled high.
REQ-030 Reset values:
- State IDLE; miso=0; data_out=0; new_data=0; busy=0; tx_full=0; tx_underrun=0; bit_ctr=0.
- Synchronizer flops: sck=0, ss_n=1.
REQ-031 rst asserted during ACTIVE: abort the frame; no new_data; state IDLE after release even if ss_n is low; no new frame until ss_n goes high and then falls again.

Verification
REQ-032 Single word: load 0xA5; master sends 0x3C (sck half-period 8 clk) -> miso bits 1,0,1,0,0,1,0,1 valid at each sck rise; data_out=0x3C; one new_data pulse; tx_full 1->0 at ss_n fall.
REQ-033 Back-to-back: load 0x81; select; after first-word consumption load 0x7E; master sends 0x12, 0x34 -> new_data twice, data_out 0x12 then 0x34; miso carries 0x81 then 0x7E.
REQ-034 Underrun: no load; master sends 0xFF -> tx_underrun pulse at ss_n fall; miso constant 0; data_out=0xFF.
REQ-035 Abort: ss_n rises after 5 sck rises -> no new_data; data_out keeps its prior value; busy=0; miso=0.
REQ-036 Load collision: tx_full=1 holding 0x11; load 0x22 -> holding still 0x11; load 0x33 in the consumption cycle -> this word sends 0x11, the next sends 0x33.
REQ-037 Reset mid-frame: rst for 1 cycle after 3 bits with ss_n held low -> all outputs at reset values; further sck ignored until ss_n goes high and then falls again.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with clk-domain synchronizers on sck/ss_n/mosi, a one-word TX
// holding register and gap-free back-to-back words within one selection.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             tx_full,
  output logic [WIDTH-1:0] data_out,
  output logic             new_data,
  output logic             busy,
  output logic             tx_underrun
);

  localparam int                CTR_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CTR_W-1:0]  LAST_BIT = CTR_W'(WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev, ss_prev;
  logic                   sck_cur, ss_cur, mosi_cur;
  logic                   sck_rise, sck_fall, ss_fall;
  logic [SYNC_STAGES:0]   warm;
  logic                   armed;

  logic [CTR_W-1:0] bit_ctr;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_word;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] next_tx;
  logic             start, stop, wrap, consume;

  assign sck_cur  = sck_sync[SYNC_STAGES-1];
  assign ss_cur   = ss_sync[SYNC_STAGES-1];
  assign mosi_cur = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_cur & ~sck_prev;
  assign sck_fall = ~sck_cur & sck_prev;
  assign ss_fall  = ss_prev & ~ss_cur;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what a synchronizer chain needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b1;
      warm      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_cur;
      ss_prev   <= ss_cur;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      // The chain resets to "deselected"; only a high seen after it has refilled
      // from the pin may arm frame start, so a held-low ss_n cannot fake a fall.
      armed     <= armed | (warm[SYNC_STAGES] & ss_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    wrap       = 1'b0;
    case (state)
      IDLE: begin
        if (armed && ss_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_cur) begin
          state_next = IDLE;
          stop       = 1'b1;
        end else if (sck_rise && bit_ctr == LAST_BIT) begin
          wrap = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign consume = start | wrap;
  assign next_tx = tx_full ? hold : '0;
  assign rx_next = {rx_shift, mosi_cur};
  assign busy    = (state == ACTIVE);

  // NOTE: the holding and TX registers are reset as well, so a frame after rst
  // can never shift out a stale word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= consume & ~tx_full;
      if (consume) begin
        // A load coinciding with consumption refills the slot just emptied.
        if (load) begin
          hold    <= data_in;
          tx_full <= 1'b1;
        end else begin
          tx_full <= 1'b0;
        end
      end else if (load && !tx_full) begin
        hold    <= data_in;
        tx_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_ctr  <= '0;
      rx_shift <= '0;
      tx_word  <= '0;
      data_out <= '0;
      new_data <= 1'b0;
      miso     <= 1'b0;
    end else begin
      new_data <= wrap;
      if (start) begin
        bit_ctr  <= '0;
        rx_shift <= '0;
        tx_word  <= next_tx;
        miso     <= next_tx[WIDTH-1];
      end else if (state == ACTIVE) begin
        if (stop) begin
          bit_ctr  <= '0;
          rx_shift <= '0;
          miso     <= 1'b0;
        end else if (sck_rise) begin
          rx_shift <= rx_next[WIDTH-2:0];
          if (wrap) begin
            data_out <= rx_next;
            bit_ctr  <= '0;
            tx_word  <= next_tx;
          end else begin
            bit_ctr <= bit_ctr + CTR_W'(1);
          end
        end else if (sck_fall) begin
          miso <= tx_word[LAST_BIT - bit_ctr];
        end
      end else begin
        miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: a bit-banged mode-0 master plus a word-level
// model of the TX holding slot, received words and pulse counts.
module tb_spi_slave;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, sck, ss_n, mosi, load;
  logic         miso, tx_full, new_data, busy, tx_underrun;
  logic [W-1:0] data_in, data_out;

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .data_in(data_in), .load(load), .tx_full(tx_full), .data_out(data_out),
    .new_data(new_data), .busy(busy), .tx_underrun(tx_underrun)
  );

  int n_vec = 0;
  int n_err = 0;
  int nd_cnt = 0;
  int ur_cnt = 0;

  always @(posedge clk) begin
    if (new_data === 1'b1)    nd_cnt++;
    if (tx_underrun === 1'b1) ur_cnt++;
  end

  // Reference model: one-word slot, last received word, expected pulse counts.
  logic         m_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_data_out = '0;
  int           m_nd = 0;
  int           m_ur = 0;
  logic [W-1:0] words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_load(input logic [W-1:0] v);
    if (!m_full) begin
      m_hold = v;
      m_full = 1'b1;
    end
  endtask

  task automatic m_take(output logic [W-1:0] w);
    w = m_full ? m_hold : '0;
    if (!m_full) m_ur++;
    m_full = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    data_in = v;
    load    = 1'b1;
    cyc(1);
    load    = 1'b0;
    m_load(v);
  endtask

  // One mode-0 bit: mosi changes while sck is low, miso is taken just before the rise.
  task automatic send_bit(input logic b, input int hp, output logic m);
    mosi = b;
    cyc(hp);
    m    = miso;
    sck  = 1'b1;
    cyc(hp);
    sck  = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_miso"}, miso, 1'b0);
  endtask

  // Sends every entry of words[] in one selection; optionally loads load_val in the
  // middle of word load_word, or holds load high across the selecting edge.
  task automatic frame(input int hp, input int load_word, input logic [W-1:0] load_val,
                       input bit collide, input logic [W-1:0] col_val);
    logic [W-1:0] exp_tx, got;
    logic         m;
    m_take(exp_tx);
    if (collide) begin
      data_in = col_val;
      load    = 1'b1;
      m_load(col_val);
    end
    ss_n = 1'b0;
    cyc(collide ? 8 : 4 + int'($urandom_range(0, 4)));
    load = 1'b0;
    check("busy_selected", busy, 1'b1);
    for (int k = 0; k < words.size(); k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        send_bit(words[k][i], hp, m);
        got[i] = m;
        if (i == W - 1) check("tx_full_after_take", tx_full, m_full);
        if (k == load_word && i == 4) do_load(load_val);
      end
      check("miso_word", got, exp_tx);
      m_data_out = words[k];
      m_nd++;
      m_take(exp_tx);
      check("data_out", data_out, m_data_out);
      check("new_data_count", nd_cnt, m_nd);
    end
    cyc(4);
    ss_n = 1'b1;
    cyc(6);
    check_idle("end_frame");
    check("underrun_count", ur_cnt, m_ur);
    check("tx_full_idle", tx_full, m_full);
  endtask

  task automatic one_word_frame(input logic [W-1:0] w, input int hp);
    words.delete();
    words.push_back(w);
    frame(hp, -1, '0, 1'b0, '0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tmp;
    logic         m;
    int           nw, hp, lw;
    bit           col;

    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; load = 1'b0; data_in = '0;
    cyc(3);
    check("rst_miso", miso, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_new_data", new_data, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_underrun", tx_underrun, 1'b0);
    rst = 1'b0;
    cyc(8);

    // Single word with a preloaded reply.
    do_load(8'hA5);
    check("tx_full_loaded", tx_full, 1'b1);
    one_word_frame(8'h3C, 8);

    // Back-to-back words, second reply loaded after the first is consumed.
    do_load(8'h81);
    words.delete();
    words.push_back(8'h12);
    words.push_back(8'h34);
    frame(6, 0, 8'h7E, 1'b0, '0);

    // Underrun: nothing loaded.
    one_word_frame(8'hFF, 5);

    // Abort after five rises: nothing received, slot already consumed.
    do_load(8'hC3);
    m_take(tmp);
    ss_n = 1'b0;
    cyc(5);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 4, m);
    cyc(2);
    ss_n = 1'b1;
    cyc(6);
    check("abort_new_data", nd_cnt, m_nd);
    check("abort_data_out", data_out, m_data_out);
    check_idle("abort");
    check("abort_tx_full", tx_full, 1'b0);

    // Load collision: second load ignored, load during consumption captured.
    do_load(8'h11);
    do_load(8'h22);
    words.delete();
    words.push_back(8'h5A);
    words.push_back(8'hE7);
    frame(5, -1, '0, 1'b1, 8'h33);

    // Reset mid-frame with ss_n held low, then sck keeps toggling.
    do_load(8'h99);
    ss_n = 1'b0;
    cyc(5);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 4, m);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_full = 1'b0;
    m_data_out = '0;
    check("midrst_miso", miso, 1'b0);
    check("midrst_data_out", data_out, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tx_full", tx_full, 1'b0);
    check("midrst_new_data", new_data, 1'b0);
    for (int i = 0; i < 2 * W; i++) send_bit(1'($urandom), 4, m);
    check("midrst_ignored_nd", nd_cnt, m_nd);
    check_idle("midrst_ignored");
    check("midrst_underrun", ur_cnt, m_ur);
    ss_n = 1'b1;
    cyc(8);
    one_word_frame(8'h6D, 4);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
      nw = int'($urandom_range(1, 3));
      hp = int'($urandom_range(4, 10));
      lw = int'($urandom_range(0, 3));
      col = m_full && ($urandom_range(0, 3) == 0);
      words.delete();
      for (int k = 0; k < nw; k++) words.push_back(W'($urandom));
      frame(hp, lw, W'($urandom), col, W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
